// File: rtl/comparator.sv
// n-bit magnitude comparator with one-hot combinational flags and a
// one-cycle registered copy that carries its own valid bit.
module comparator #(
  parameter int n      = 32,
  parameter int SIGNED = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         less,
  output logic         equal,
  output logic         greater,
  output logic         less_q,
  output logic         equal_q,
  output logic         greater_q,
  output logic         valid_q
);

  // Inverting the MSB maps two's-complement order onto unsigned order,
  // so a single unsigned compare serves both modes (and n=1 needs no special case).
  localparam logic [n-1:0] MSB_BIT  = n'(1) << (n - 1);
  localparam logic [n-1:0] MSB_FLIP = (SIGNED != 0) ? MSB_BIT : '0;

  function automatic logic [2:0] cmp_flags(input logic [n-1:0] x, input logic [n-1:0] y);
    logic [2:0] f;
    if (x < y)       f = 3'b100;
    else if (x == y) f = 3'b010;
    else             f = 3'b001;
    return f;
  endfunction

  logic [n-1:0] w_a_key_p0;
  logic [n-1:0] w_b_key_p0;
  logic [2:0]   w_flags_p0;

  logic         r_less_p1;
  logic         r_equal_p1;
  logic         r_greater_p1;
  logic         r_vld_p1;

  // Stage p0: combinational compare
  assign w_a_key_p0 = a ^ MSB_FLIP;
  assign w_b_key_p0 = b ^ MSB_FLIP;
  assign w_flags_p0 = cmp_flags(w_a_key_p0, w_b_key_p0);

  assign less    = w_flags_p0[2];
  assign equal   = w_flags_p0[1];
  assign greater = w_flags_p0[0];

  // Stage p1: registered flags; reset clears them to all-zero (not one-hot)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_less_p1    <= 1'b0;
      r_equal_p1   <= 1'b0;
      r_greater_p1 <= 1'b0;
      r_vld_p1     <= 1'b0;
    end else begin
      r_less_p1    <= w_flags_p0[2];
      r_equal_p1   <= w_flags_p0[1];
      r_greater_p1 <= w_flags_p0[0];
      r_vld_p1     <= 1'b1;
    end
  end

  assign less_q    = r_less_p1;
  assign equal_q   = r_equal_p1;
  assign greater_q = r_greater_p1;
  assign valid_q   = r_vld_p1;

endmodule

// File: tb/tb_comparator.sv
// Bench for comparator: directed cases on 1/4/32-bit instances, then a
// scoreboarded random sweep of the 32-bit unsigned and signed instances.
module tb_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a4, b4;
  logic [31:0] a32, b32;
  logic        a1, b1;

  // Packing per instance: {less, equal, greater, less_q, equal_q, greater_q, valid_q}
  logic [6:0] o4u, o4s, o32u, o32s, o1s;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbq[$];

  always #5 clk = ~clk;

  comparator #(.n(4), .SIGNED(0)) u4u (
    .clk(clk), .rst(rst), .a(a4), .b(b4),
    .less(o4u[6]), .equal(o4u[5]), .greater(o4u[4]),
    .less_q(o4u[3]), .equal_q(o4u[2]), .greater_q(o4u[1]), .valid_q(o4u[0]));

  comparator #(.n(4), .SIGNED(1)) u4s (
    .clk(clk), .rst(rst), .a(a4), .b(b4),
    .less(o4s[6]), .equal(o4s[5]), .greater(o4s[4]),
    .less_q(o4s[3]), .equal_q(o4s[2]), .greater_q(o4s[1]), .valid_q(o4s[0]));

  comparator #(.n(32), .SIGNED(0)) u32u (
    .clk(clk), .rst(rst), .a(a32), .b(b32),
    .less(o32u[6]), .equal(o32u[5]), .greater(o32u[4]),
    .less_q(o32u[3]), .equal_q(o32u[2]), .greater_q(o32u[1]), .valid_q(o32u[0]));

  comparator #(.n(32), .SIGNED(1)) u32s (
    .clk(clk), .rst(rst), .a(a32), .b(b32),
    .less(o32s[6]), .equal(o32s[5]), .greater(o32s[4]),
    .less_q(o32s[3]), .equal_q(o32s[2]), .greater_q(o32s[1]), .valid_q(o32s[0]));

  comparator #(.n(1), .SIGNED(1)) u1s (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .less(o1s[6]), .equal(o1s[5]), .greater(o1s[4]),
    .less_q(o1s[3]), .equal_q(o1s[2]), .greater_q(o1s[1]), .valid_q(o1s[0]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference compare through sign-extended 64-bit integers
  function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y,
                                         input int w, input bit sg);
    longint sx, sy;
    sx = longint'(x);
    sy = longint'(y);
    if (sg && x[w-1]) sx = sx - (64'sd1 <<< w);
    if (sg && y[w-1]) sy = sy - (64'sd1 <<< w);
    if (sx < sy)       return 3'b100;
    else if (sx == sy) return 3'b010;
    else               return 3'b001;
  endfunction

  // Called just after a rising edge: drive, check comb flags, push expected *_q
  task automatic drive32(input logic [31:0] va, input logic [31:0] vb, input logic vr);
    logic [2:0] eu, es;
    logic [3:0] qu, qs;
    a32 = va;
    b32 = vb;
    rst = vr;
    #1;
    eu = ref_cmp(va, vb, 32, 1'b0);
    es = ref_cmp(va, vb, 32, 1'b1);
    chk("comb32u", {29'd0, o32u[6:4]}, {29'd0, eu});
    chk("comb32s", {29'd0, o32s[6:4]}, {29'd0, es});
    chk("onehot32u", $countones(o32u[6:4]), 1);
    chk("onehot32s", $countones(o32s[6:4]), 1);
    qu = vr ? 4'b0000 : {eu, 1'b1};
    qs = vr ? 4'b0000 : {es, 1'b1};
    sbq.push_back({qu, qs});
  endtask

  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("reg32u", {28'd0, o32u[3:0]}, {28'd0, e[7:4]});
      chk("reg32s", {28'd0, o32s[3:0]}, {28'd0, e[3:0]});
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rr;

    // Reset held for two edges with a=3, b=5
    rst = 1'b1; a4 = 4'd3; b4 = 4'd5; a32 = '0; b32 = '0; a1 = 1'b0; b1 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst_q4u", {28'd0, o4u[3:0]}, 32'd0);
      chk("rst_q32s", {28'd0, o32s[3:0]}, 32'd0);
      chk("rst_comb4u", {29'd0, o4u[6:4]}, {29'd0, 3'b100});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_q4u", {28'd0, o4u[3:0]}, {28'd0, 4'b1001});

    // Latency: equal registered, then a steps to 6 just after the edge
    a4 = 4'd5;
    #1;
    chk("lat_comb_eq", {29'd0, o4u[6:4]}, {29'd0, 3'b010});
    @(posedge clk);
    #1;
    chk("lat_q_eq", {28'd0, o4u[3:0]}, {28'd0, 4'b0101});
    a4 = 4'd6;
    #1;
    chk("lat_comb_gt", {29'd0, o4u[6:4]}, {29'd0, 3'b001});
    chk("lat_q_hold", {28'd0, o4u[3:0]}, {28'd0, 4'b0101});
    @(posedge clk);
    #1;
    chk("lat_q_gt", {28'd0, o4u[3:0]}, {28'd0, 4'b0011});

    // 4-bit opcode-style constants
    a4 = 4'd8; b4 = 4'd8; #1;
    chk("u4_8_8", {29'd0, o4u[6:4]}, {29'd0, 3'b010});
    a4 = 4'd9; #1;
    chk("u4_9_8", {29'd0, o4u[6:4]}, {29'd0, 3'b001});
    a4 = 4'd0; #1;
    chk("u4_0_8", {29'd0, o4u[6:4]}, {29'd0, 3'b100});
    a4 = 4'b1000; b4 = 4'b0111; #1;
    chk("s4_m8_7", {29'd0, o4s[6:4]}, {29'd0, 3'b100});
    chk("u4_8_7", {29'd0, o4u[6:4]}, {29'd0, 3'b001});
    a4 = 4'b1111; b4 = 4'b1110; #1;
    chk("s4_m1_m2", {29'd0, o4s[6:4]}, {29'd0, 3'b001});

    // 32-bit boundaries
    a32 = 32'hFFFF_FFFF; b32 = 32'h0; #1;
    chk("u32_max_0", {29'd0, o32u[6:4]}, {29'd0, 3'b001});
    chk("s32_m1_0", {29'd0, o32s[6:4]}, {29'd0, 3'b100});
    a32 = 32'h0; #1;
    chk("u32_0_0", {29'd0, o32u[6:4]}, {29'd0, 3'b010});
    a32 = 32'h7FFF_FFFF; b32 = 32'h8000_0000; #1;
    chk("u32_7f_80", {29'd0, o32u[6:4]}, {29'd0, 3'b100});
    chk("s32_7f_80", {29'd0, o32s[6:4]}, {29'd0, 3'b001});

    // n=1 signed: the single bit is the sign
    a1 = 1'b1; b1 = 1'b0; #1;
    chk("s1_1_0", {29'd0, o1s[6:4]}, {29'd0, 3'b100});
    a1 = 1'b0; b1 = 1'b1; #1;
    chk("s1_0_1", {29'd0, o1s[6:4]}, {29'd0, 3'b001});
    a1 = 1'b1; b1 = 1'b1; #1;
    chk("s1_1_1", {29'd0, o1s[6:4]}, {29'd0, 3'b010});

    // Comb flags track inputs while rst is high; registers clear on that edge only
    @(posedge clk);
    #1;
    rst = 1'b1; a4 = 4'd2; b4 = 4'd1; #1;
    chk("rst_comb_track", {29'd0, o4u[6:4]}, {29'd0, 3'b001});
    @(posedge clk);
    #1;
    chk("mid_rst_q", {28'd0, o4u[3:0]}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_reload", {28'd0, o4u[3:0]}, {28'd0, 4'b0011});

    // Random sweep with scoreboard; occasional mid-stream reset
    for (int i = 0; i < 1000; i++) begin
      tick();
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: rb = $urandom;
      endcase
      rr = ($urandom_range(0, 49) == 0);
      drive32(ra, rb, rr);
    end
    tick();
    chk("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
